// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// ALU operation codes, ALUOp classes and the opcodes the controller recognises.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd11
  } state_t;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t add_ctrl = 3'b000;
  localparam alu_ctrl_t sub_ctrl = 3'b001;
  localparam alu_ctrl_t and_ctrl = 3'b010;
  localparam alu_ctrl_t or_ctrl  = 3'b011;
  localparam alu_ctrl_t slt_ctrl = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = 2'b01;
      OP_BEQ:  imm_src_of = 2'b10;
      OP_JAL:  imm_src_of = 2'b11;
      default: imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mc_control_fsm_if;
  import riscv_ctrl_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Z;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  alu_ctrl_t  ALU_control;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Z,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Z,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal
  );

endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// Maps ALUOp plus the instruction function fields onto the 3-bit ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  alu_control
);

  // Operation select; op5 separates R-type sub from addi with instr[30] set.
  always_comb begin
    alu_control = add_ctrl;
    case (alu_op)
      ALUOP_ADD: alu_control = add_ctrl;
      ALUOP_SUB: alu_control = sub_ctrl;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) alu_control = sub_ctrl;
            else                 alu_control = add_ctrl;
          end
          3'b010:  alu_control = slt_ctrl;
          3'b110:  alu_control = or_ctrl;
          3'b111:  alu_control = and_ctrl;
          default: alu_control = add_ctrl;
        endcase
      end
      default: alu_control = add_ctrl;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V main controller: Moore state decode of datapath selects and
// enables, with branch resolution from Z and a sticky illegal-opcode flag.
module mc_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mc_control_fsm_if.master    ctrl
);

  state_t     state_r;
  state_t     state_next_s;
  logic       illegal_r;
  logic       pcupdate_s;
  logic       branch_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  alu_ctrl_t  alu_control_s;

  // State register and sticky illegal flag, set on the edge that enters ERROR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == ERROR) illegal_r <= 1'b1;
      else                       illegal_r <= illegal_r;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next_s = ERROR;
    pcupdate_s   = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pcupdate_s   = 1'b1;
        state_next_s = DECODE;
      end
      DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (ctrl.op)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_R:         state_next_s = EXECUTER;
          OP_I:         state_next_s = EXECUTEI;
          OP_BEQ:       state_next_s = BEQ;
          OP_JAL:       state_next_s = JAL;
          default:      state_next_s = ERROR;
        endcase
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (ctrl.op == OP_LW)      state_next_s = MEMREAD;
        else if (ctrl.op == OP_SW) state_next_s = MEMWRITE;
        else                       state_next_s = ERROR;
      end
      MEMREAD: begin
        adr_src_s    = 1'b1;
        state_next_s = MEMWB;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        adr_src_s    = 1'b1;
        mem_write_s  = 1'b1;
        state_next_s = FETCH;
      end
      EXECUTER: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = ALUOP_FUNCT;
        state_next_s = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        alu_op_s     = ALUOP_FUNCT;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        reg_write_s  = 1'b1;
        state_next_s = FETCH;
      end
      BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = ALUOP_SUB;
        branch_s     = 1'b1;
        state_next_s = FETCH;
      end
      JAL: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        pcupdate_s   = 1'b1;
        state_next_s = ALUWB;
      end
      ERROR:   state_next_s = ERROR;
      default: state_next_s = ERROR;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (ctrl.funct3),
    .funct7b5    (ctrl.funct7b5),
    .op5         (ctrl.op[5]),
    .alu_control (alu_control_s)
  );

  // Write enables are gated by rst_n so an in-flight write drops without a clock edge.
  assign ctrl.PCWrite     = rst_n & (pcupdate_s | (branch_s & ctrl.Z));
  assign ctrl.MemWrite    = rst_n & mem_write_s;
  assign ctrl.IRWrite     = rst_n & ir_write_s;
  assign ctrl.RegWrite    = rst_n & reg_write_s;
  assign ctrl.AdrSrc      = adr_src_s;
  assign ctrl.ResultSrc   = result_src_s;
  assign ctrl.ALUSrcA     = alu_src_a_s;
  assign ctrl.ALUSrcB     = alu_src_b_s;
  assign ctrl.ImmSrc      = imm_src_of(ctrl.op);
  assign ctrl.ALU_control = alu_control_s;
  assign ctrl.illegal     = illegal_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm with hand-computed expected outputs.
module tb_mc_control_fsm;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] enables();
    return {4'b0000, bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite};
  endfunction

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] alu;
    logic [1:0] srcb;
  } exe_vec_t;

  exe_vec_t exe_tbl [5];

  typedef struct {
    logic zdec;
    logic zbeq;
    logic pcw;
  } beq_vec_t;

  beq_vec_t beq_tbl [3];

  initial begin
    vectors     = 0;
    miscompares = 0;
    exe_tbl[0] = '{7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00};
    exe_tbl[1] = '{7'b0110011, 3'b111, 1'b0, 3'b010, 2'b00};
    exe_tbl[2] = '{7'b0110011, 3'b110, 1'b0, 3'b011, 2'b00};
    exe_tbl[3] = '{7'b0110011, 3'b010, 1'b0, 3'b101, 2'b00};
    exe_tbl[4] = '{7'b0010011, 3'b000, 1'b1, 3'b000, 2'b01};
    beq_tbl[0] = '{1'b0, 1'b1, 1'b1};
    beq_tbl[1] = '{1'b0, 1'b0, 1'b0};
    beq_tbl[2] = '{1'b1, 1'b0, 1'b0};

    rst_n        = 1'b0;
    bus.op       = 7'b0000011;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Z        = 1'b0;

    // Reset held for two cycles: all enables low, FETCH decode otherwise.
    step();
    check_val("rst_en_0", enables(), 8'h00);
    check_val("rst_illegal", 8'(bus.illegal), 8'h00);
    step();
    check_val("rst_en_1", enables(), 8'h00);
    check_val("rst_srcb", 8'(bus.ALUSrcB), 8'h02);

    // lw: FETCH DECODE MEMADR MEMREAD MEMWB.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("lw_fetch_en", enables(), 8'h0A);
    check_val("lw_fetch_res", 8'(bus.ResultSrc), 8'h02);
    step();
    check_val("lw_dec_en", enables(), 8'h00);
    check_val("lw_dec_srca", 8'(bus.ALUSrcA), 8'h01);
    check_val("lw_dec_srcb", 8'(bus.ALUSrcB), 8'h01);
    step();
    check_val("lw_madr_alu", 8'(bus.ALU_control), 8'h00);
    check_val("lw_madr_srca", 8'(bus.ALUSrcA), 8'h02);
    step();
    check_val("lw_mread_adr", 8'(bus.AdrSrc), 8'h01);
    check_val("lw_mread_en", enables(), 8'h00);
    step();
    check_val("lw_mwb_en", enables(), 8'h01);
    check_val("lw_mwb_res", 8'(bus.ResultSrc), 8'h01);
    step();
    check_val("lw_end_fetch", enables(), 8'h0A);

    // sw: four cycles, never writes the register file.
    bus.op = 7'b0100011;
    #1;
    check_val("sw_immsrc", 8'(bus.ImmSrc), 8'h01);
    step();
    check_val("sw_dec_en", enables(), 8'h00);
    step();
    check_val("sw_madr_en", enables(), 8'h00);
    step();
    check_val("sw_mwr_en", enables(), 8'h04);
    check_val("sw_mwr_adr", 8'(bus.AdrSrc), 8'h01);
    step();
    check_val("sw_end_fetch", enables(), 8'h0A);

    // R-type and I-type execute decode.
    for (int i = 0; i < 5; i++) begin
      bus.op       = exe_tbl[i].op;
      bus.funct3   = exe_tbl[i].f3;
      bus.funct7b5 = exe_tbl[i].f7;
      step();
      step();
      check_val($sformatf("exe%0d_alu", i), 8'(bus.ALU_control), 8'(exe_tbl[i].alu));
      check_val($sformatf("exe%0d_srca", i), 8'(bus.ALUSrcA), 8'h02);
      check_val($sformatf("exe%0d_srcb", i), 8'(bus.ALUSrcB), 8'(exe_tbl[i].srcb));
      step();
      check_val($sformatf("exe%0d_wb", i), enables(), 8'h01);
      step();
      check_val($sformatf("exe%0d_fetch", i), enables(), 8'h0A);
    end
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;

    // beq: only Z during the BEQ cycle decides PCWrite.
    for (int i = 0; i < 3; i++) begin
      bus.op = 7'b1100011;
      bus.Z  = 1'b0;
      step();
      bus.Z = beq_tbl[i].zdec;
      #1;
      check_val($sformatf("beq%0d_dec_pcw", i), 8'(bus.PCWrite), 8'h00);
      @(negedge clk);
      bus.Z = beq_tbl[i].zbeq;
      #1;
      check_val($sformatf("beq%0d_pcw", i), 8'(bus.PCWrite), 8'(beq_tbl[i].pcw));
      check_val($sformatf("beq%0d_alu", i), 8'(bus.ALU_control), 8'h01);
      check_val($sformatf("beq%0d_imm", i), 8'(bus.ImmSrc), 8'h02);
      bus.Z = 1'b0;
      step();
      check_val($sformatf("beq%0d_fetch", i), enables(), 8'h0A);
    end

    // jal: PC update in JAL, link write in ALUWB.
    bus.op = 7'b1101111;
    step();
    step();
    check_val("jal_en", enables(), 8'h08);
    check_val("jal_srca", 8'(bus.ALUSrcA), 8'h01);
    check_val("jal_srcb", 8'(bus.ALUSrcB), 8'h02);
    check_val("jal_imm", 8'(bus.ImmSrc), 8'h03);
    step();
    check_val("jal_wb", enables(), 8'h01);
    step();
    check_val("jal_fetch", enables(), 8'h0A);

    // Illegal opcode: ERROR is held and the flag is sticky.
    bus.op = 7'b1111111;
    #1;
    check_val("ill_pre_flag", 8'(bus.illegal), 8'h00);
    step();
    step();
    bus.Z = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check_val($sformatf("ill_en%0d", i), enables(), 8'h00);
      check_val($sformatf("ill_flag%0d", i), 8'(bus.illegal), 8'h01);
      step();
    end
    bus.Z = 1'b0;

    // Reset pulse clears the flag and restarts at FETCH.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rstp_flag", 8'(bus.illegal), 8'h00);
    check_val("rstp_en", enables(), 8'h00);
    bus.op = 7'b0100011;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rstp_fetch", enables(), 8'h0A);

    // Reset dropped mid-MEMWRITE suppresses MemWrite without a clock edge.
    step();
    step();
    step();
    check_val("mwr_pre", 8'(bus.MemWrite), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mwr_async", 8'(bus.MemWrite), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mwr_after_fetch", enables(), 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
